chip8_arith_sequencer: RTL and testbench
========================================

CHIP8_ARITH_SEQUENCER -- requirements
Module: chip8_arith_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; all state changes occur on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  request to execute opcode; sampled only in IDLE.
REQ-005 opcode  input  16  instruction; captured when start is accepted.
REQ-006 busy  output  1  high whenever state != IDLE.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 illegal  output  1  high with done when the opcode is not a supported 8XYN form.
REQ-009 reg_addr  output  4  register-file address.
REQ-010 reg_rdata  input  8  register-file read data, valid one cycle after reg_addr.
REQ-011 reg_we  output  1  register-file write strobe.
REQ-012 reg_wdata  output  8  register-file write data.
REQ-013 alu_in1, alu_in2  output  16 each  ALU operands, 8-bit values zero-extended.
REQ-014 alu_sel  output  ALU_f  ALU function select.
REQ-015 alu_out  input  16  ALU result (combinational).
REQ-016 alu_carry  input  1  ALU carry/compare flag.

Function
REQ-017 FSM states SHALL be IDLE, READ_X, READ_Y, EXEC, WRITE_V, WRITE_F, DONE.
REQ-018 IDLE: start=1 with opcode[15:12]=8 and N in {0,1,2,3,4,5,6,7,E} -> capture opcode, go to READ_X; other opcodes with start=1 -> DONE with illegal=1; start=0 -> stay in IDLE.
REQ-019 READ_X: reg_addr=X (opcode[11:8]); next state READ_Y.
REQ-020 READ_Y: latch reg_rdata as vx; reg_addr=Y (opcode[7:4]); next state EXEC.
REQ-021 EXEC: latch reg_rdata as vy; drive the ALU per REQ-022; latch alu_out[7:0] as result and compute the flag per REQ-023; next state WRITE_V.
REQ-022 ALU mapping (in1, in2, sel): N=0 (Vy, 0, OR); N=1 (Vx, Vy, OR); N=2 (Vx, Vy, AND); N=3 (Vx, Vy, XOR); N=4 (Vx, Vy, ADD); N=5 (Vx, Vy, MINUS); N=6 (Vx, 1, RSHIFT); N=7 (Vy, Vx, MINUS); N=E (Vx, 1, LSHIFT).
REQ-023 Flag: N=4 -> alu_carry; N=5 -> (Vx>=Vy); N=7 -> (Vy>=Vx); N=6 -> Vx[0]; N=E -> Vx[7]; N=0..3 -> no VF write.
REQ-024 Result SHALL be alu_out[7:0]; upper bits are discarded, so subtraction wraps modulo 256.
REQ-025 WRITE_V: reg_we=1, reg_addr=X, reg_wdata=result; next state WRITE_F for N in {4,5,6,7,E}, else DONE.
REQ-026 WRITE_F: reg_we=1, reg_addr=F, reg_wdata={7'b0, flag}; next state DONE.
REQ-027 When X=F, the VF write follows the Vx write, so the flag value SHALL be the final content of VF.
REQ-028 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-029 Latency from the start cycle (cycle 0): done in cycle 6 for flag ops, cycle 5 for N=0..3, cycle 1 for illegal opcodes.
REQ-030 An illegal opcode SHALL cause no register writes.
REQ-031 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-032 reg_we SHALL be 0 in every state other than WRITE_V and WRITE_F.
REQ-033 alu_in1, alu_in2 and alu_sel SHALL hold 0, 0 and ALU_f_OR outside EXEC.

Reset
REQ-034 reset_n=0 at a clock edge SHALL force IDLE and set busy=0, done=0, illegal=0, reg_we=0, reg_addr=0, reg_wdata=0, alu_in1=0, alu_in2=0, alu_sel=ALU_f_OR.
REQ-035 Reset in any state, including WRITE_V and WRITE_F, SHALL abort the operation with no further writes and no done pulse.

Verification
REQ-036 V3=0xF0, V4=0x20, start 0x8344 -> V3=0x10, VF=1, done in cycle 6.
REQ-037 V1=0x05, V2=0x07, start 0x8125 -> V1=0xFE, VF=0; then V1=V2=0x07, start 0x8125 -> V1=0x00, VF=1.
REQ-038 VF=0x81, start 0x8F0E -> VF=0x01 (flag overwrites result); then VA=0x03, start 0x8A06 -> VA=0x01, VF=1.
REQ-039 start 0x8129 -> done and illegal high in cycle 1, no reg_we; start 0x1234 -> same response; start pulsed again in cycle 2 of a legal op -> ignored.
REQ-040 start 0x8561, reset_n=0 during WRITE_V -> next cycle state IDLE, all outputs at reset values, no done pulse.

Source files
------------

// File: rtl/chip8_arith_sequencer.sv
// CHIP-8 8XYN arithmetic sequencer: reads Vx/Vy from an external register
// file, drives an external ALU, then writes the result to Vx and the flag to VF.

package chip8_alu_pkg;
  typedef enum logic [2:0] {
    ALU_f_OR     = 3'd0,
    ALU_f_AND    = 3'd1,
    ALU_f_XOR    = 3'd2,
    ALU_f_ADD    = 3'd3,
    ALU_f_MINUS  = 3'd4,
    ALU_f_RSHIFT = 3'd5,
    ALU_f_LSHIFT = 3'd6
  } ALU_f;
endpackage

module chip8_arith_sequencer
  import chip8_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  reg_addr,
  input  logic [7:0]  reg_rdata,
  output logic        reg_we,
  output logic [7:0]  reg_wdata,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output ALU_f        alu_sel,
  input  logic [15:0] alu_out,
  input  logic        alu_carry
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ_X  = 3'd1,
    READ_Y  = 3'd2,
    EXEC    = 3'd3,
    WRITE_V = 3'd4,
    WRITE_F = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] opcode_q, opcode_d;   // X, Y, N fields only; the 8 nibble is implied
  logic [7:0]  vx_q, vx_d;
  logic [7:0]  result_q, result_d;
  logic        flag_q, flag_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  op_x, op_y, op_n;
  logic        start_legal;
  logic        has_flag;
  logic [7:0]  unused_alu_hi;

  assign op_x = opcode_q[11:8];
  assign op_y = opcode_q[7:4];
  assign op_n = opcode_q[3:0];

  // Upper ALU bits are deliberately dropped so arithmetic wraps modulo 256
  assign unused_alu_hi = alu_out[15:8];

  // Decode which incoming opcodes are supported 8XYN forms
  always_comb begin
    start_legal = 1'b0;
    if (opcode[15:12] == 4'h8) begin
      start_legal = (opcode[3:0] <= 4'h7) || (opcode[3:0] == 4'hE);
    end
  end

  // Ops that produce a VF write after the Vx write
  always_comb begin
    has_flag = (op_n == 4'h4) || (op_n == 4'h5) || (op_n == 4'h6) ||
               (op_n == 4'h7) || (op_n == 4'hE);
  end

  // Next-state and Moore outputs; every output idles at zero / OR
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    vx_d      = vx_q;
    result_d  = result_q;
    flag_d    = flag_q;
    illegal_d = illegal_q;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    illegal   = 1'b0;
    reg_addr  = 4'h0;
    reg_we    = 1'b0;
    reg_wdata = 8'h00;
    alu_in1   = 16'h0000;
    alu_in2   = 16'h0000;
    alu_sel   = ALU_f_OR;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_legal) begin
            opcode_d  = opcode[11:0];
            illegal_d = 1'b0;
            state_d   = READ_X;
          end else begin
            illegal_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      READ_X: begin
        reg_addr = op_x;
        state_d  = READ_Y;
      end
      READ_Y: begin
        // Data for X (addressed last cycle) arrives now
        vx_d     = reg_rdata;
        reg_addr = op_y;
        state_d  = EXEC;
      end
      EXEC: begin
        // reg_rdata now holds Vy; it is consumed directly by the ALU and flag
        flag_d = 1'b0;
        case (op_n)
          4'h0: begin alu_in1 = {8'h00, reg_rdata}; alu_in2 = 16'h0000; alu_sel = ALU_f_OR; end
          4'h1: begin alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; alu_sel = ALU_f_OR; end
          4'h2: begin alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; alu_sel = ALU_f_AND; end
          4'h3: begin alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; alu_sel = ALU_f_XOR; end
          4'h4: begin
            alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; alu_sel = ALU_f_ADD;
            flag_d  = alu_carry;
          end
          4'h5: begin
            alu_in1 = {8'h00, vx_q}; alu_in2 = {8'h00, reg_rdata}; alu_sel = ALU_f_MINUS;
            flag_d  = (vx_q >= reg_rdata);
          end
          4'h6: begin
            alu_in1 = {8'h00, vx_q}; alu_in2 = 16'h0001; alu_sel = ALU_f_RSHIFT;
            flag_d  = vx_q[0];
          end
          4'h7: begin
            alu_in1 = {8'h00, reg_rdata}; alu_in2 = {8'h00, vx_q}; alu_sel = ALU_f_MINUS;
            flag_d  = (reg_rdata >= vx_q);
          end
          4'hE: begin
            alu_in1 = {8'h00, vx_q}; alu_in2 = 16'h0001; alu_sel = ALU_f_LSHIFT;
            flag_d  = vx_q[7];
          end
          default: begin
            alu_sel = ALU_f_OR;
          end
        endcase
        result_d = alu_out[7:0];
        state_d  = WRITE_V;
      end
      WRITE_V: begin
        reg_we    = 1'b1;
        reg_addr  = op_x;
        reg_wdata = result_q;
        state_d   = has_flag ? WRITE_F : DONE;
      end
      WRITE_F: begin
        // Written after Vx so the flag wins when X is F
        reg_we    = 1'b1;
        reg_addr  = 4'hF;
        reg_wdata = {7'b0000000, flag_q};
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        illegal = illegal_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      opcode_q  <= 12'h000;
      vx_q      <= 8'h00;
      result_q  <= 8'h00;
      flag_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      vx_q      <= vx_d;
      result_q  <= result_d;
      flag_q    <= flag_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_chip8_arith_sequencer.sv
// Directed bench for chip8_arith_sequencer with a behavioural register file and ALU.

module tb_chip8_arith_sequencer;
  import chip8_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] opcode = 16'h0000;
  logic        busy, done, illegal, reg_we;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_rdata = 8'h00;
  logic [7:0]  reg_wdata;
  logic [15:0] alu_in1, alu_in2, alu_out;
  ALU_f        alu_sel;
  logic        alu_carry;

  logic [7:0]  rf [16];
  int          wr_cnt = 0;
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = 4'h0;
  logic [7:0]  pre_data = 8'h00;

  int cnt_total = 0;
  int cnt_bad = 0;

  always #5 clk = ~clk;

  chip8_arith_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .illegal(illegal),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  // Register file: one-cycle read latency, write on strobe, bench preload port
  always @(posedge clk) begin
    reg_rdata <= rf[reg_addr];
    if (reg_we) begin
      rf[reg_addr] <= reg_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (pre_we) begin
      rf[pre_addr] <= pre_data;
    end
  end

  // Combinational 8-bit-style ALU
  always_comb begin
    alu_out   = 16'h0000;
    alu_carry = 1'b0;
    case (alu_sel)
      ALU_f_OR:     alu_out = alu_in1 | alu_in2;
      ALU_f_AND:    alu_out = alu_in1 & alu_in2;
      ALU_f_XOR:    alu_out = alu_in1 ^ alu_in2;
      ALU_f_ADD:    begin alu_out = alu_in1 + alu_in2; alu_carry = (alu_out > 16'h00FF); end
      ALU_f_MINUS:  alu_out = alu_in1 - alu_in2;
      ALU_f_RSHIFT: alu_out = alu_in1 >> alu_in2;
      ALU_f_LSHIFT: alu_out = alu_in1 << alu_in2;
      default:      alu_out = 16'h0000;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cnt_total++;
    if (obs !== exp) begin
      cnt_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".done"}, done, 0);
    check_eq({tag, ".ill"}, illegal, 0);
    check_eq({tag, ".we"}, reg_we, 0);
    check_eq({tag, ".addr"}, reg_addr, 0);
    check_eq({tag, ".wdata"}, reg_wdata, 0);
    check_eq({tag, ".in1"}, alu_in1, 0);
    check_eq({tag, ".in2"}, alu_in2, 0);
    check_eq({tag, ".sel"}, alu_sel, ALU_f_OR);
  endtask

  // Issue one opcode, measure done latency, illegal flag and write count
  task automatic run_op(input string tag, input logic [15:0] op, input int exp_lat,
                        input bit exp_ill, input int exp_wr, input bit poke);
    int cyc;
    bit got;
    bit ill;
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1; opcode = op;
    cyc = 0; got = 0; ill = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke && cyc == 2) begin start = 1'b1; opcode = 16'h8014; end
      if (poke && cyc == 3) start = 1'b0;
      if (done) begin got = 1; ill = illegal; end
    end
    check_eq({tag, ".lat"}, got ? cyc : 32'hFFFF_FFFF, exp_lat);
    check_eq({tag, ".ill"}, ill, exp_ill);
    @(negedge clk);
    check_eq({tag, ".busy_after"}, busy, 0);
    check_eq({tag, ".done_1cyc"}, done, 0);
    check_eq({tag, ".writes"}, wr_cnt - w0, exp_wr);
    if (poke) begin
      repeat (3) @(negedge clk);
      check_eq({tag, ".no_queue"}, busy, 0);
    end
  endtask

  initial begin
    int w0;
    bit seen;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;

    // Reset
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // 8344 add with carry
    set_reg(4'h3, 8'hF0); set_reg(4'h4, 8'h20);
    run_op("add", 16'h8344, 6, 0, 2, 0);
    check_eq("add.v3", rf[3], 8'h10);
    check_eq("add.vf", rf[15], 8'h01);

    // 8125 subtract with borrow, then equal operands
    set_reg(4'h1, 8'h05); set_reg(4'h2, 8'h07);
    run_op("sub1", 16'h8125, 6, 0, 2, 0);
    check_eq("sub1.v1", rf[1], 8'hFE);
    check_eq("sub1.vf", rf[15], 8'h00);
    set_reg(4'h1, 8'h07);
    run_op("sub2", 16'h8125, 6, 0, 2, 0);
    check_eq("sub2.v1", rf[1], 8'h00);
    check_eq("sub2.vf", rf[15], 8'h01);

    // 8F0E: flag overwrites result in VF
    set_reg(4'hF, 8'h81);
    run_op("shlF", 16'h8F0E, 6, 0, 2, 0);
    check_eq("shlF.vf", rf[15], 8'h01);

    // 8A06 shift right
    set_reg(4'hA, 8'h03); set_reg(4'hF, 8'h00);
    run_op("shr", 16'h8A06, 6, 0, 2, 0);
    check_eq("shr.va", rf[10], 8'h01);
    check_eq("shr.vf", rf[15], 8'h01);

    // 8897 reverse subtract
    set_reg(4'h8, 8'h10); set_reg(4'h9, 8'h30); set_reg(4'hF, 8'h00);
    run_op("subn", 16'h8897, 6, 0, 2, 0);
    check_eq("subn.v8", rf[8], 8'h20);
    check_eq("subn.vf", rf[15], 8'h01);

    // Logic ops: no VF write, latency 5
    set_reg(4'h6, 8'h3C); set_reg(4'h7, 8'hA5); set_reg(4'hF, 8'h5A);
    run_op("and", 16'h8672, 5, 0, 1, 0);
    check_eq("and.v6", rf[6], 8'h24);
    check_eq("and.vf", rf[15], 8'h5A);
    run_op("xor", 16'h8673, 5, 0, 1, 0);
    check_eq("xor.v6", rf[6], 8'h81);
    run_op("or", 16'h8671, 5, 0, 1, 0);
    check_eq("or.v6", rf[6], 8'hA5);
    set_reg(4'h6, 8'h00);
    run_op("mov", 16'h8670, 5, 0, 1, 0);
    check_eq("mov.v6", rf[6], 8'hA5);

    // Illegal opcodes
    run_op("ill8129", 16'h8129, 1, 1, 0, 0);
    run_op("ill1234", 16'h1234, 1, 1, 0, 0);

    // Start pulsed while busy is ignored and not queued
    set_reg(4'h1, 8'h11); set_reg(4'h2, 8'h22);
    run_op("poke", 16'h8123, 5, 0, 1, 1);
    check_eq("poke.v1", rf[1], 8'h33);

    // Reset during WRITE_V aborts without done or further writes
    set_reg(4'h5, 8'h0F); set_reg(4'h6, 8'hF0);
    @(negedge clk);
    start = 1'b1; opcode = 16'h8561;
    @(negedge clk); start = 1'b0;      // cycle 1
    repeat (3) @(negedge clk);         // cycle 4: WRITE_V
    check_eq("rst.in_wv", reg_we, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst");
    reset_n = 1'b1;
    w0 = wr_cnt;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || reg_we) seen = 1;
    end
    check_eq("rst.no_done_we", seen, 0);
    check_eq("rst.no_writes", wr_cnt - w0, 0);

    $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
    $finish;
  end

endmodule
